// File: rtl/kuznechik_arbiter_pkg.sv
// Shared definitions for the kuznechik cipher-core arbiter.
// Holds state encodings, block width and the default watchdog limit.
package kuznechik_defs;

  localparam int BLOCK_W     = 128;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DELIVER
  } state_e;

endpackage

// File: rtl/kuznechik_rr_picker.sv
// Round-robin picker: first requester at or after ptr_i,
// wrapping to the lowest requester below ptr_i.
module kuznechik_rr_picker #(
  parameter int N_CLIENTS = 2,
  parameter int ID_W      = 3
) (
  input  logic [N_CLIENTS-1:0] req_i,
  input  logic [ID_W-1:0]      ptr_i,
  output logic                 any_o,
  output logic [ID_W-1:0]      idx_o
);

  logic            hi_any;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Descending scan so the lowest matching index is written last.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) >= ptr_i) begin
          hi_any = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
  end

  assign any_o = |req_i;
  assign idx_o = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/kuznechik_arbiter.sv
// Round-robin sharing of one kuznechik cipher core between clients,
// with result routing back to the requester and a busy->valid watchdog.
module kuznechik_arbiter
  import kuznechik_defs::*;
#(
  parameter int N_CLIENTS      = 2,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic [N_CLIENTS-1:0]           cl_req_i,
  input  logic [BLOCK_W*N_CLIENTS-1:0]   cl_data_i,
  output logic [N_CLIENTS-1:0]           cl_gnt_o,
  output logic [N_CLIENTS-1:0]           cl_valid_o,
  output logic [BLOCK_W-1:0]             cl_data_o,
  input  logic [N_CLIENTS-1:0]           cl_ack_i,
  output logic                           core_request_o,
  output logic [BLOCK_W-1:0]             core_data_o,
  output logic                           core_ack_o,
  input  logic                           core_busy_i,
  input  logic                           core_valid_i,
  input  logic [BLOCK_W-1:0]             core_data_i,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [ID_W-1:0]                err_id_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        cur_q, cur_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [N_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [N_CLIENTS-1:0]   vld_q, vld_d;
  logic [BLOCK_W-1:0]     res_q, res_d;
  logic [BLOCK_W-1:0]     pt_q, pt_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [ID_W-1:0]        eid_q, eid_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic                   pick_any;
  logic [ID_W-1:0]        pick_id;
  logic [N_CLIENTS-1:0]   pick_oh;
  logic [N_CLIENTS-1:0]   cur_oh;
  logic [BLOCK_W-1:0]     pick_pt;
  logic [ID_W-1:0]        nxt_ptr;

  kuznechik_rr_picker #(
    .N_CLIENTS (N_CLIENTS),
    .ID_W      (ID_W)
  ) u_pick (
    .req_i (cl_req_i),
    .ptr_i (rr_q),
    .any_o (pick_any),
    .idx_o (pick_id)
  );

  always_comb begin
    pick_oh = '0;
    cur_oh  = '0;
    pick_pt = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      pick_oh[i] = (pick_id == ID_W'(i));
      cur_oh[i]  = (cur_q == ID_W'(i));
      if (pick_id == ID_W'(i)) begin
        pick_pt = cl_data_i[i*BLOCK_W +: BLOCK_W];
      end
    end
  end

  assign nxt_ptr = (cur_q == ID_W'(N_CLIENTS - 1)) ?
                   '0 : cur_q + ID_W'(1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    vld_d   = vld_q;
    res_d   = res_q;
    pt_d    = pt_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    eid_d   = eid_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          cur_d   = pick_id;
          pt_d    = pick_pt;
          gnt_d   = pick_oh;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_valid_i) begin
          state_d = ST_CAPTURE;
        end else if (core_busy_i) begin
          wd_d    = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_valid_i) begin
          state_d = ST_CAPTURE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          eid_d   = cur_q;
          ack_d   = 1'b1;
          rr_d    = nxt_ptr;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_CAPTURE: begin
        res_d   = core_data_i;
        ack_d   = 1'b1;
        vld_d   = cur_oh;
        state_d = ST_DELIVER;
      end
      ST_DELIVER: begin
        if (|(cl_ack_i & cur_oh)) begin
          vld_d   = '0;
          rr_d    = nxt_ptr;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      vld_q   <= '0;
      res_q   <= '0;
      pt_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      eid_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      pt_q    <= pt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      eid_q   <= eid_d;
      wd_q    <= wd_d;
    end
  end

  assign cl_gnt_o       = gnt_q;
  assign cl_valid_o     = vld_q;
  assign cl_data_o      = res_q;
  assign core_request_o = (state_q == ST_ISSUE);
  assign core_data_o    = pt_q;
  assign core_ack_o     = ack_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign err_o          = err_q;
  assign err_id_o       = eid_q;

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Directed bench for kuznechik_arbiter with a behavioural core model
// that knows the GOST reference vector and xors other blocks.
module tb_kuznechik_arbiter;

  localparam int N   = 2;
  localparam int IW  = 3;
  localparam int TO  = 16;
  localparam int LAT = 3;

  localparam logic [127:0] P0 = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] C0 = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N-1:0]     cl_req;
  logic [128*N-1:0] cl_data;
  logic [N-1:0]     cl_gnt;
  logic [N-1:0]     cl_valid;
  logic [127:0]     cl_dout;
  logic [N-1:0]     cl_ack;
  logic             core_req;
  logic [127:0]     core_din;
  logic             core_ack;
  logic             core_busy;
  logic             core_valid;
  logic [127:0]     core_dout;
  logic             busy;
  logic             err;
  logic [IW-1:0]    err_id;

  logic             hang;
  logic [127:0]     core_pt;
  int               core_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ack_cnt     = 0;
  int vld_cnt     = 0;

  always #5 clk = ~clk;

  kuznechik_arbiter #(
    .N_CLIENTS      (N),
    .ID_W           (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .cl_req_i       (cl_req),
    .cl_data_i      (cl_data),
    .cl_gnt_o       (cl_gnt),
    .cl_valid_o     (cl_valid),
    .cl_data_o      (cl_dout),
    .cl_ack_i       (cl_ack),
    .core_request_o (core_req),
    .core_data_o    (core_din),
    .core_ack_o     (core_ack),
    .core_busy_i    (core_busy),
    .core_valid_i   (core_valid),
    .core_data_i    (core_dout),
    .busy_o         (busy),
    .err_o          (err),
    .err_id_o       (err_id)
  );

  function automatic logic [127:0] enc(input logic [127:0] d);
    return (d == P0) ? C0 : (d ^ {16{8'hA5}});
  endfunction

  // Core model: busy after request, valid LAT+1 cycles later, or
  // never when hang is set; ack returns it to idle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_busy  <= 1'b0;
      core_valid <= 1'b0;
      core_dout  <= '0;
      core_pt    <= '0;
      core_cnt   <= 0;
    end else if (core_ack) begin
      core_busy  <= 1'b0;
      core_valid <= 1'b0;
    end else if (!core_busy && !core_valid && core_req) begin
      core_busy <= 1'b1;
      core_cnt  <= LAT;
      core_pt   <= core_din;
    end else if (core_busy && !hang) begin
      if (core_cnt == 0) begin
        core_busy  <= 1'b0;
        core_valid <= 1'b1;
        core_dout  <= enc(core_pt);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ack_cnt <= ack_cnt + (core_ack ? 1 : 0);
    vld_cnt <= vld_cnt + ((cl_valid != 0) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (cl_gnt != 0) begin
        g = cl_gnt;
        break;
      end
    end
  endtask

  task automatic wait_valid(output logic [N-1:0] v, output int lat);
    int vc;
    vc  = -1;
    v   = '0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (core_valid && vc < 0) vc = cyc;
      if (cl_valid != 0) begin
        v   = cl_valid;
        lat = cyc - vc;
        break;
      end
    end
  endtask

  task automatic wait_req_drop();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!core_req) break;
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_gnt"},   128'(cl_gnt),   '0);
    chk({pfx, "_vld"},   128'(cl_valid), '0);
    chk({pfx, "_dout"},  cl_dout,        '0);
    chk({pfx, "_creq"},  128'(core_req), '0);
    chk({pfx, "_cdin"},  core_din,       '0);
    chk({pfx, "_cack"},  128'(core_ack), '0);
    chk({pfx, "_busy"},  128'(busy),     '0);
    chk({pfx, "_err"},   128'(err),      '0);
    chk({pfx, "_errid"}, 128'(err_id),   '0);
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] v;
    int lat, a0, v0, c0, t;
    logic stable;

    resetn  = 1'b0;
    cl_req  = '0;
    cl_data = '0;
    cl_ack  = '0;
    hang    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // single client, reference vector
    cl_data = {P1, P0};
    cl_req  = 2'b01;
    tick();
    chk("t1_gnt", 128'(cl_gnt), 128'(2'b01));
    chk("t1_creq", 128'(core_req), 128'd1);
    chk("t1_cdin", core_din, P0);
    chk("t1_busy", 128'(busy), 128'd1);
    cl_req = '0;
    wait_valid(v, lat);
    chk("t1_vld", 128'(v), 128'(2'b01));
    chk("t1_dout", cl_dout, C0);
    chk("t1_lat", 128'(lat), 128'd2);
    repeat (3) tick();
    chk("t1_hold_vld", 128'(cl_valid), 128'(2'b01));
    chk("t1_hold_dout", cl_dout, C0);
    cl_ack = 2'b01;
    tick();
    cl_ack = '0;
    chk("t1_idle", 128'(busy), 128'd0);
    chk("t1_vld_clr", 128'(cl_valid), 128'd0);

    // contention from reset pointer
    resetn = 1'b0;
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    cl_data = {P1, P2};
    cl_req  = 2'b11;
    wait_gnt(g);
    chk("t2_gnt0", 128'(g), 128'(2'b01));
    cl_req = 2'b10;
    wait_valid(v, lat);
    chk("t2_vld0", 128'(v), 128'(2'b01));
    chk("t2_dout0", cl_dout, enc(P2));
    cl_ack = 2'b01;
    tick();
    cl_ack = '0;
    wait_gnt(g);
    chk("t2_gnt1", 128'(g), 128'(2'b10));
    cl_req = '0;
    wait_valid(v, lat);
    chk("t2_vld1", 128'(v), 128'(2'b10));
    chk("t2_dout1", cl_dout, enc(P1));
    cl_ack = 2'b10;
    tick();
    cl_ack = '0;

    // continuous requests rotate
    cl_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_gnt(g);
      chk("t3_rr", 128'(g), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      wait_valid(v, lat);
      cl_ack = v;
      tick();
      cl_ack = '0;
    end
    cl_req = '0;
    tick();

    // delayed ack with a foreign ack bit asserted
    a0     = ack_cnt;
    cl_req = 2'b11;
    wait_gnt(g);
    chk("t4_gnt0", 128'(g), 128'(2'b01));
    cl_req = 2'b10;
    wait_valid(v, lat);
    chk("t4_vld", 128'(v), 128'(2'b01));
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cl_ack = 2'b10;
      tick();
      if (cl_valid !== 2'b01 || cl_dout !== enc(P2) || cl_gnt !== 2'b00)
        stable = 1'b0;
    end
    chk("t4_stable", 128'(stable), 128'd1);
    chk("t4_ack_once", 128'(ack_cnt - a0), 128'd1);
    cl_ack = 2'b01;
    tick();
    cl_ack = '0;
    wait_gnt(g);
    chk("t4_gnt1", 128'(g), 128'(2'b10));
    cl_req = '0;
    wait_valid(v, lat);
    chk("t4_dout1", cl_dout, enc(P1));
    cl_ack = 2'b10;
    tick();
    cl_ack = '0;

    // watchdog abort for client 1
    hang   = 1'b1;
    a0     = ack_cnt;
    v0     = vld_cnt;
    cl_req = 2'b10;
    wait_gnt(g);
    chk("t5_gnt", 128'(g), 128'(2'b10));
    cl_req = '0;
    wait_req_drop();
    c0 = cyc;
    t  = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!busy) begin
        t = cyc - c0;
        break;
      end
    end
    chk("t5_cycles", 128'(t), 128'd16);
    chk("t5_err", 128'(err), 128'd1);
    chk("t5_errid", 128'(err_id), 128'd1);
    tick();
    tick();
    chk("t5_novld", 128'(vld_cnt - v0), 128'd0);
    chk("t5_ack", 128'(ack_cnt - a0), 128'd1);
    hang   = 1'b0;
    cl_req = 2'b01;
    wait_gnt(g);
    chk("t5_next_gnt", 128'(g), 128'(2'b01));
    cl_req = '0;
    wait_valid(v, lat);
    chk("t5_next_dout", cl_dout, enc(P2));
    chk("t5_err_sticky", 128'(err), 128'd1);
    cl_ack = 2'b01;
    tick();
    cl_ack = '0;

    // asynchronous reset while waiting on the core
    hang   = 1'b1;
    cl_req = 2'b01;
    wait_gnt(g);
    cl_req = '0;
    wait_req_drop();
    chk("t6_inwait", 128'(busy), 128'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk_zero("t6");
    hang = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    v0 = vld_cnt;
    repeat (10) tick();
    chk("t6_novld", 128'(vld_cnt - v0), 128'd0);
    chk("t6_idle", 128'(busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
